// File: rtl/hwpe_stream_tcdm_reader.sv
// Strided TCDM read unit: issues 32-bit reads and replays responses as a 32-bit HWPE stream.
// Optional stall counter port stall_cnt_o is enabled by defining HWPE_STREAM_TCDM_READER_PERF_EN.
module hwpe_stream_tcdm_reader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [31:0] stride_i,
  input  logic [15:0] len_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        tcdm_req_o,
  input  logic        tcdm_gnt_i,
  output logic [31:0] tcdm_add_o,
  output logic        tcdm_we_n_o,
  output logic [3:0]  tcdm_be_o,
  output logic [31:0] tcdm_data_o,
  input  logic [31:0] tcdm_r_data_i,
  input  logic        tcdm_r_valid_i,
  output logic        stream_valid_o,
  input  logic        stream_ready_i,
  output logic [31:0] stream_data_o,
  output logic [3:0]  stream_strb_o
`ifdef HWPE_STREAM_TCDM_READER_PERF_EN
  ,
  output logic [31:0] stall_cnt_o
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  state_e state_q, state_d;

  logic [31:0]   addr_q, stride_q;
  logic [15:0]   len_q, issued_q, popped_q;
  logic [CW-1:0] outst_q, outst_d, fifo_cnt_q, occupancy;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic          done_q, done_d;
  logic          gnt_fire, rsp_fire, push, pop, last_pop, start_run, abort;

  // Credit covers both in-flight reads and buffered beats, so a response always finds room.
  assign occupancy  = outst_q + fifo_cnt_q;
  assign tcdm_req_o = (state_q == RUN) && (issued_q < len_q) && (occupancy < DEPTH_C);
  assign gnt_fire   = tcdm_req_o && tcdm_gnt_i;
  assign rsp_fire   = tcdm_r_valid_i && (outst_q != '0);
  assign abort      = (state_q == RUN) && clear_i;
  assign push       = rsp_fire && (state_q == RUN) && !clear_i;
  assign pop        = stream_valid_o && stream_ready_i;
  assign last_pop   = pop && (popped_q == len_q - 16'd1);
  assign start_run  = (state_q == IDLE) && start_i && (len_i != 16'd0);

  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign tcdm_add_o     = addr_q;
  assign tcdm_we_n_o    = 1'b1;
  assign tcdm_be_o      = 4'hF;
  assign tcdm_data_o    = 32'h0;
  assign stream_valid_o = (state_q == RUN) && (fifo_cnt_q != '0);
  assign stream_data_o  = fifo_mem[rd_ptr_q];
  assign stream_strb_o  = 4'hF;

  always_comb begin
    outst_d = outst_q;
    case ({gnt_fire, rsp_fire})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase
  end

  // An abort decides between IDLE and FLUSH on the post-edge outstanding count,
  // so a grant landing in the same cycle as clear_i is still waited for.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i == 16'd0) done_d = 1'b1;
          else                state_d = RUN;
        end
      end
      RUN: begin
        if (clear_i) begin
          state_d = (outst_d == '0) ? IDLE : FLUSH;
        end else if (last_pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      FLUSH: begin
        if (outst_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
      outst_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      outst_q <= outst_d;
      if (start_run) begin
        addr_q   <= base_addr_i;
        stride_q <= stride_i;
        len_q    <= len_i;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (gnt_fire) begin
          addr_q   <= addr_q + stride_q;
          issued_q <= issued_q + 16'd1;
        end
        if (pop) popped_q <= popped_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || abort) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= tcdm_r_data_i;
  end

`ifdef HWPE_STREAM_TCDM_READER_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i || ((state_q == IDLE) && start_i)) begin
      stall_cnt_q <= '0;
    end else if (stream_valid_o && !stream_ready_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hwpe_stream_tcdm_reader.sv
// Scoreboard bench for hwpe_stream_tcdm_reader: a TCDM memory model answers reads and a
// negedge monitor checks addresses, stream beats, handshake stability and done timing.
module tb_hwpe_stream_tcdm_reader;

  logic        clk;
  logic        rst_i, clear_i, start_i;
  logic [31:0] base_addr_i, stride_i;
  logic [15:0] len_i;
  logic        busy_o, done_o;
  logic        tcdm_req_o, tcdm_gnt_i, tcdm_we_n_o, tcdm_r_valid_i;
  logic [31:0] tcdm_add_o, tcdm_data_o, tcdm_r_data_i;
  logic [3:0]  tcdm_be_o, stream_strb_o;
  logic        stream_valid_o, stream_ready_i;
  logic [31:0] stream_data_o;
`ifdef HWPE_STREAM_TCDM_READER_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  hwpe_stream_tcdm_reader #(.FIFO_DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .base_addr_i    (base_addr_i),
    .stride_i       (stride_i),
    .len_i          (len_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .tcdm_req_o     (tcdm_req_o),
    .tcdm_gnt_i     (tcdm_gnt_i),
    .tcdm_add_o     (tcdm_add_o),
    .tcdm_we_n_o    (tcdm_we_n_o),
    .tcdm_be_o      (tcdm_be_o),
    .tcdm_data_o    (tcdm_data_o),
    .tcdm_r_data_i  (tcdm_r_data_i),
    .tcdm_r_valid_i (tcdm_r_valid_i),
    .stream_valid_o (stream_valid_o),
    .stream_ready_i (stream_ready_i),
    .stream_data_o  (stream_data_o),
    .stream_strb_o  (stream_strb_o)
`ifdef HWPE_STREAM_TCDM_READER_PERF_EN
    ,
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } rsp_t;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  rsp_t        resp_q[$];

  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned last_grant_cyc = 0;
  int unsigned last_rvalid_cyc = 0;
  int          grant_cnt = 0;
  int          beats_left = 0;
  int          gnt_mode = 0;
  int          gnt_budget = 0;
  int          withhold_left = 0;
  bit          ready_level = 1'b1;
  bit          ready_rand = 1'b0;
  bit          done_due = 1'b0;
  bit          b2b_chk = 1'b0;
  bit          hold_chk_en = 1'b1;

  bit          prev_req_wait = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_add = '0;
  logic [31:0] prev_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // TCDM slave and stream sink: drive grant, in-order responses and ready just after each edge.
  initial begin
    tcdm_gnt_i     = 1'b0;
    tcdm_r_valid_i = 1'b0;
    tcdm_r_data_i  = '0;
    stream_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (gnt_mode)
        0:       tcdm_gnt_i = 1'b1;
        1:       tcdm_gnt_i = ($urandom_range(0, 99) < 60);
        2:       tcdm_gnt_i = !((grant_cnt == 1) && (withhold_left > 0));
        default: tcdm_gnt_i = (grant_cnt < gnt_budget);
      endcase
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
        tcdm_r_valid_i  = 1'b1;
        tcdm_r_data_i   = resp_q[0].data;
        last_rvalid_cyc = cyc;
        void'(resp_q.pop_front());
      end else begin
        tcdm_r_valid_i = 1'b0;
        tcdm_r_data_i  = $urandom;
      end
      stream_ready_i = ready_rand ? ($urandom_range(0, 99) < 70) : ready_level;
    end
  end

  // Monitor: every handshake is judged on the values that will be sampled at the next edge.
  always @(negedge clk) begin
    bit   exp_done;
    rsp_t r;
    if (!rst_i) begin
      exp_done = done_due;
      done_due = 1'b0;
      if (done_o || exp_done) check_output("done_pulse", 32'(done_o), 32'(exp_done));
      if (hold_chk_en && prev_req_wait) begin
        check_output("req_hold", 32'(tcdm_req_o), 32'd1);
        check_output("add_hold", tcdm_add_o, prev_add);
      end
      if (hold_chk_en && prev_stall) begin
        check_output("valid_hold", 32'(stream_valid_o), 32'd1);
        check_output("data_hold", stream_data_o, prev_data);
      end
      if (tcdm_req_o && tcdm_gnt_i) begin
        grant_cnt++;
        if (exp_addr_q.size() == 0) begin
          check_output("unexpected_req", tcdm_add_o, 32'hFFFF_FFFF);
        end else begin
          check_output("req_addr", tcdm_add_o, exp_addr_q.pop_front());
        end
        if (b2b_chk && grant_cnt > 1) check_output("b2b_grant", cyc, last_grant_cyc + 1);
        last_grant_cyc = cyc;
        r.due  = cyc + lat;
        r.data = mem_word(tcdm_add_o);
        resp_q.push_back(r);
      end
      if (gnt_mode == 2 && tcdm_req_o && !tcdm_gnt_i && grant_cnt == 1 && withhold_left > 0)
        withhold_left--;
      if (stream_valid_o && stream_ready_i) begin
        check_output("beat_strb", 32'(stream_strb_o), 32'hF);
        if (exp_data_q.size() == 0) begin
          check_output("unexpected_beat", stream_data_o, 32'hFFFF_FFFF);
        end else begin
          check_output("beat_data", stream_data_o, exp_data_q.pop_front());
        end
        if (beats_left > 0) begin
          beats_left--;
          if (beats_left == 0) done_due = 1'b1;
        end
      end
      prev_req_wait = tcdm_req_o && !tcdm_gnt_i;
      prev_add      = tcdm_add_o;
      prev_stall    = stream_valid_o && !stream_ready_i;
      prev_data     = stream_data_o;
    end
  end

  task automatic apply_stimulus(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] len);
    logic [31:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = base + stride * 32'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem_word(a));
    end
    beats_left  = int'(len);
    grant_cnt   = 0;
    base_addr_i = base;
    stride_i    = stride;
    len_i       = len;
    start_i     = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    if (len == 16'd0) done_due = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((beats_left != 0 || busy_o) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output({name, "_timeout"}, 32'(n < 3000), 32'd1);
    check_output({name, "_reqs_left"}, 32'(exp_addr_q.size()), 32'd0);
    check_output({name, "_beats_left"}, 32'(exp_data_q.size()), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    int valid_seen;
    rst_i       = 1'b1;
    clear_i     = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    stride_i    = '0;
    len_i       = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_done", 32'(done_o), 32'd0);
    check_output("rst_req", 32'(tcdm_req_o), 32'd0);
    check_output("rst_valid", 32'(stream_valid_o), 32'd0);
    check_output("rst_add", tcdm_add_o, 32'd0);
    check_output("const_we_n", 32'(tcdm_we_n_o), 32'd1);
    check_output("const_be", 32'(tcdm_be_o), 32'hF);
    check_output("const_wdata", tcdm_data_o, 32'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic back-to-back job");
    lat = 1; gnt_mode = 0; ready_rand = 1'b0; ready_level = 1'b1; b2b_chk = 1'b1;
    apply_stimulus(32'h1000, 32'd4, 16'd8);
    check_output("basic_busy", 32'(busy_o), 32'd1);
    wait_done("basic");
    check_output("basic_grants", 32'(grant_cnt), 32'd8);
    b2b_chk = 1'b0;

    $display("[TB] sink stalled, credit limit");
    lat = 3; ready_level = 1'b0;
    apply_stimulus(32'h2000, 32'd8, 16'd8);
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check_output("credit_grants", 32'(grant_cnt), 32'd4);
    check_output("credit_req_low", 32'(tcdm_req_o), 32'd0);
    check_output("credit_valid", 32'(stream_valid_o), 32'd1);
    ready_level = 1'b1;
    wait_done("credit");

    $display("[TB] grant withheld on second request");
    lat = 2; gnt_mode = 2; withhold_left = 5;
    apply_stimulus(32'h3000, 32'd12, 16'd6);
    wait_done("withhold");
    check_output("withhold_stalled", 32'(withhold_left), 32'd0);
    gnt_mode = 0;

    $display("[TB] address wrap");
    lat = 1;
    apply_stimulus(32'hFFFF_FFF8, 32'd4, 16'd4);
    wait_done("wrap");

    $display("[TB] zero-length job");
    apply_stimulus(32'h4000, 32'd4, 16'd0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check_output("len0_grants", 32'(grant_cnt), 32'd0);
    check_output("len0_busy", 32'(busy_o), 32'd0);

    $display("[TB] start while busy");
    lat = 2; ready_rand = 1'b1;
    apply_stimulus(32'h5000, 32'd4, 16'd10);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    base_addr_i = 32'hDEAD_0000; stride_i = 32'd16; len_i = 16'd3; start_i = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    start_i = 1'b0;
    wait_done("restart");
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check_output("restart_grants", 32'(grant_cnt), 32'd10);
    ready_rand = 1'b0;

    $display("[TB] clear with reads outstanding");
    lat = 4; gnt_mode = 3; gnt_budget = 2; ready_level = 1'b0;
    apply_stimulus(32'h6000, 32'd4, 16'd6);
    n = 0;
    while (grant_cnt < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_output("clear_setup", 32'(grant_cnt), 32'd2);
    hold_chk_en = 1'b0;
    clear_i = 1'b1;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    exp_addr_q.delete();
    exp_data_q.delete();
    beats_left = 0;
    check_output("clear_req_drop", 32'(tcdm_req_o), 32'd0);
    check_output("clear_busy", 32'(busy_o), 32'd1);
    n = 0;
    valid_seen = 0;
    while (busy_o && n < 40) begin
      if (stream_valid_o) valid_seen++;
      @(posedge clk);
      #1;
      n++;
    end
    check_output("flush_exit", 32'(busy_o), 32'd0);
    check_output("flush_valid", 32'(valid_seen), 32'd0);
    check_output("flush_rsp_drained", 32'(resp_q.size()), 32'd0);
    check_output("flush_idle_cycle", cyc, last_rvalid_cyc + 1);
    check_output("flush_grants", 32'(grant_cnt), 32'd2);
    hold_chk_en = 1'b1;
    gnt_mode = 0; ready_level = 1'b1; lat = 2;
    apply_stimulus(32'h7000, 32'd4, 16'd5);
    wait_done("recover");

    $display("[TB] randomized jobs");
    gnt_mode = 1; ready_rand = 1'b1;
    for (int j = 0; j < 12; j++) begin
      lat = $urandom_range(1, 4);
      apply_stimulus($urandom, $urandom, 16'($urandom_range(1, 12)));
      wait_done("rand_job");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
